spi_txn_sequencer: RTL
======================

// Module: spi_txn_sequencer
// PURPOSE
//  Sequences multi-byte SPI transactions on top of the single-byte SPI shift engine (trigger/busy/tx_data/rx_data).
//  Accepts a command (length, chip select, keep-CS flag) and streams TX bytes from a FIFO.
//  Fires one engine transfer per byte and collects RX bytes into a FIFO.
//  Owns chip-select timing; sits between the bus-side SPI peripheral registers and the byte engine.
// PARAMETERS
//  NUM_CS      2  number of active-low chip selects
//  LEN_W       8  command length field width; transfer count = cmd_len+1 (1..2**LEN_W)
//  CS_DELAY    2  clk cycles of CS setup before first byte and hold after last byte (>=1)
//  FIFO_DEPTH  4  entries in each of TX and RX FIFO (power of 2, >=2)
// PORTS
//  clk          in   1                 system clock
//  rst          in   1                 synchronous active-high reset
//  cmd_valid    in   1                 command offered
//  cmd_ready    out  1                 high only in IDLE; accept on valid&ready
//  cmd_len      in   LEN_W             bytes-1
//  cmd_cs       in   $clog2(NUM_CS)    chip select index (out-of-range -> no CS asserted, bytes still clocked)
//  cmd_keep_cs  in   1                 leave CS asserted after last byte (skip hold/deassert)
//  tx_valid/tx_ready/tx_data  in/out/in  1/1/8  TX byte stream into TX FIFO (ready = !full)
//  rx_valid/rx_ready/rx_data  out/in/out 1/1/8  RX byte stream from RX FIFO (valid = !empty)
//  byte_trigger out  1                 one-cycle start pulse to byte engine
//  byte_busy    in   1                 engine busy (rises cycle after trigger)
//  byte_tx      out  8                 byte to shift; held stable for whole transfer
//  byte_rx      in   8                 engine result, valid when byte_busy falls
//  cs_n         out  NUM_CS            chip selects, active low
//  busy         out  1                 high whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, cs_n all 1, byte_trigger 0, byte_tx 8'h00, both FIFOs empty, busy 0, cmd_ready 1.
//  Handshake: a push/pop occurs only on valid&ready. FIFOs are fall-through, simultaneous push+pop legal when not empty/full.
//  FSM:
//   IDLE     : on cmd accept latch len/cs/keep, count=0. If CS already held (keep from prior cmd, same cs) -> LOAD; else drive cs_n, load delay ctr -> SETUP.
//   SETUP    : count down CS_DELAY cycles -> LOAD.
//   LOAD     : wait until TX FIFO !empty AND RX FIFO !full; then pop TX into byte_tx, pulse byte_trigger -> WAIT_HI.
//   WAIT_HI  : wait byte_busy==1 -> WAIT_LO (guards 1-cycle engine start latency).
//   WAIT_LO  : on byte_busy==0 push byte_rx into RX FIFO (space guaranteed by LOAD check); if count==len -> HOLD or IDLE(keep) else count++ -> LOAD.
//   HOLD     : CS_DELAY cycles with CS still low, then cs_n all 1 -> IDLE.
//  Keep-CS: a held CS is released on the next command with keep=0 after its HOLD, or on a command to a different cs index (deassert, then SETUP on new cs).
//  TX underflow and RX full stall in LOAD with CS held; no byte is dropped or duplicated.
//  byte_trigger is exactly 1 cycle; never asserted outside LOAD->WAIT_HI transition.
//  Counter width LEN_W; compare count==len, so len=all-ones gives 2**LEN_W bytes without overflow.
//  Reset mid-transaction: immediate IDLE, CS released, FIFOs flushed; engine also reset by rst.
//  Minimum per-byte overhead beyond engine time: 2 cycles (LOAD, WAIT_LO detect).
// STRUCTURE
//  spi_pkg: typedef enum logic [2:0] {IDLE,SETUP,LOAD,WAIT_HI,WAIT_LO,HOLD} spi_seq_state_t; localparam SPI_BYTE_W=8.
//  Sub-module: spi_byte_fifo (param DEPTH, WIDTH), instantiated twice for TX and RX; FSM and counters inline.
// TESTING (bench includes behavioural byte engine with busy rising 1 cycle after trigger)
//  1. cmd len=0 cs=0, tx 8'hA5, engine loops back -> cs_n=2'b10 for CS_DELAY before trigger, rx_data 8'hA5, cs_n=2'b11 after hold, busy 0.
//  2. len=2, tx 11,22,33 preloaded -> 3 triggers, exactly 1 per byte, rx 11,22,33 in order, CS low continuously.
//  3. len=1, only 1 TX byte supplied, 2nd after 20 cycles -> stalls in LOAD with CS low, no trigger until 2nd byte arrives.
//  4. FIFO_DEPTH=4, len=7, rx_ready=0 -> exactly 4 triggers then stall, resumes when rx_ready=1, 8 bytes received in order.
//  5. cmd keep=1 len=0 then cmd keep=0 len=0 same cs -> CS never deasserts between, no second SETUP.
//  6. rst asserted in WAIT_LO of byte 2 of 4 -> next cycle cs_n all 1, busy 0, rx_valid 0, cmd_ready 1.

Source files
------------

// File: rtl/spi_txn_sequencer_pkg.sv
// Shared types for the SPI transaction sequencer slice.
// Holds the sequencer state encoding and the SPI byte width.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        WAIT_HI,
        WAIT_LO,
        HOLD
    } spi_seq_state_t;

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// Bus-side streams of the sequencer: command, TX bytes, RX bytes.
// master = register block / producer, slave = sequencer.
interface spi_txn_sequencer_if
    import spi_pkg::*;
#(
    parameter int NUM_CS = 2,
    parameter int LEN_W  = 8
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_W-1:0]      cmd_len;
    logic [CS_W-1:0]       cmd_cs;
    logic                  cmd_keep_cs;

    logic                  tx_valid;
    logic                  tx_ready;
    logic [SPI_BYTE_W-1:0] tx_data;

    logic                  rx_valid;
    logic                  rx_ready;
    logic [SPI_BYTE_W-1:0] rx_data;

    modport master (
        output cmd_valid, cmd_len, cmd_cs, cmd_keep_cs,
        output tx_valid, tx_data, rx_ready,
        input  cmd_ready, tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_cs, cmd_keep_cs,
        input  tx_valid, tx_data, rx_ready,
        output cmd_ready, tx_ready, rx_valid, rx_data
    );

endinterface

// File: rtl/spi_txn_sequencer_fifo.sv
// Fall-through byte FIFO (dout valid whenever !empty).
// Ports: push/din/full on write side, pop/dout/empty on read side.
module spi_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Multi-byte SPI transaction sequencer over a single-byte shift engine.
// Ports: clk/rst, bus (cmd/tx/rx streams), byte_* engine link, cs_n, busy.
module spi_txn_sequencer
    import spi_pkg::*;
#(
    parameter int NUM_CS     = 2,
    parameter int LEN_W      = 8,
    parameter int CS_DELAY   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_txn_sequencer_if.slave    bus,
    output logic                  byte_trigger,
    input  logic                  byte_busy,
    output logic [SPI_BYTE_W-1:0] byte_tx,
    input  logic [SPI_BYTE_W-1:0] byte_rx,
    output logic [NUM_CS-1:0]     cs_n,
    output logic                  busy
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int DW   = $clog2(CS_DELAY + 1);

    spi_seq_state_t        state;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      count;
    logic [CS_W-1:0]       cs_q;
    logic                  keep_q;
    logic                  held_q;
    logic [DW-1:0]         dly;

    logic                  tx_full;
    logic                  tx_empty;
    logic [SPI_BYTE_W-1:0] tx_dout;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  tx_pop;
    logic                  rx_push;
    logic                  cmd_fire;

    // Out-of-range index matches no bit, leaving every CS released.
    function automatic logic [NUM_CS-1:0] cs_decode(
        input logic [CS_W-1:0] idx
    );
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (idx == CS_W'(i))
                m[i] = 1'b0;
        return m;
    endfunction

    spi_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SPI_BYTE_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.tx_valid),
        .din   (bus.tx_data),
        .full  (tx_full),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .empty (tx_empty)
    );

    spi_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SPI_BYTE_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (byte_rx),
        .full  (rx_full),
        .pop   (bus.rx_ready),
        .dout  (bus.rx_data),
        .empty (rx_empty)
    );

    assign bus.tx_ready  = !tx_full;
    assign bus.rx_valid  = !rx_empty;
    assign bus.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

    // A byte only starts once its RX slot is reserved, so the
    // WAIT_LO push can never hit a full RX FIFO.
    assign tx_pop  = (state == LOAD) && !tx_empty && !rx_full;
    assign rx_push = (state == WAIT_LO) && !byte_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cs_n         <= '1;
            byte_trigger <= 1'b0;
            byte_tx      <= '0;
            len_q        <= '0;
            count        <= '0;
            cs_q         <= '0;
            keep_q       <= 1'b0;
            held_q       <= 1'b0;
            dly          <= '0;
        end else begin
            byte_trigger <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        len_q  <= bus.cmd_len;
                        cs_q   <= bus.cmd_cs;
                        keep_q <= bus.cmd_keep_cs;
                        count  <= '0;
                        if (held_q && bus.cmd_cs == cs_q) begin
                            state <= LOAD;
                        end else begin
                            // Switching index drops the old CS
                            // as the new one asserts.
                            cs_n   <= cs_decode(bus.cmd_cs);
                            held_q <= 1'b0;
                            dly    <= DW'(CS_DELAY - 1);
                            state  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (dly == '0)
                        state <= LOAD;
                    else
                        dly <= dly - DW'(1);
                end
                LOAD: begin
                    if (tx_pop) begin
                        byte_tx      <= tx_dout;
                        byte_trigger <= 1'b1;
                        state        <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (byte_busy)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!byte_busy) begin
                        if (count == len_q) begin
                            if (keep_q) begin
                                held_q <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                dly   <= DW'(CS_DELAY - 1);
                                state <= HOLD;
                            end
                        end else begin
                            count <= count + LEN_W'(1);
                            state <= LOAD;
                        end
                    end
                end
                HOLD: begin
                    if (dly == '0) begin
                        cs_n   <= '1;
                        held_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        dly <= dly - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
